// File: rtl/lpc_pkg.sv
// Shared LPC/TPM protocol codes, status encodings and host FSM states.
`timescale 1ns/1ps
package lpc_pkg;

  localparam logic [3:0] LpcStartTpm  = 4'b0101;
  localparam logic [3:0] CycTpmRead   = 4'b0000;
  localparam logic [3:0] CycTpmWrite  = 4'b0010;
  localparam logic [3:0] SyncReady    = 4'b0000;
  localparam logic [3:0] SyncShort    = 4'b0101;
  localparam logic [3:0] SyncLong     = 4'b0110;
  localparam logic [3:0] SyncErr      = 4'b1010;

  typedef enum logic [1:0] {
    StatusOk      = 2'b00,
    StatusSyncErr = 2'b01,
    StatusAbort   = 2'b10
  } lpc_status_e;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StCycType,
    StAddr,
    StWData,
    StHtar,
    StSync,
    StRData,
    StPtar,
    StAbort,
    StRecover
  } lpc_state_e;

endpackage

// File: rtl/lpc_sync_timer.sv
// Short-wait and long-wait SYNC counters with terminal-count flags.
`timescale 1ns/1ps
module lpc_sync_timer #(
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned LONG_TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic short_inc_i,
  input  logic long_inc_i,
  output logic short_tc_o,
  output logic long_tc_o
);

  localparam int unsigned ShortW = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned LongW  = $clog2(LONG_TIMEOUT + 1);

  logic [ShortW-1:0] r_short;
  logic [LongW-1:0]  r_long;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_short <= '0;
      r_long  <= '0;
    end else if (clr_i) begin
      r_short <= '0;
      r_long  <= '0;
    end else begin
      if (short_inc_i) r_short <= r_short + ShortW'(1);
      // Long waits must be consecutive; any short wait restarts that run.
      if (long_inc_i)       r_long <= r_long + LongW'(1);
      else if (short_inc_i) r_long <= '0;
    end
  end

  // Flag fires on the wait cycle that brings the count up to the limit.
  assign short_tc_o = short_inc_i && (r_short == ShortW'(SYNC_TIMEOUT - 1));
  assign long_tc_o  = long_inc_i && (r_long == LongW'(LONG_TIMEOUT - 1));

endmodule

// File: rtl/lpc_host.sv
// LPC host initiator: single-byte TPM read/write cycles on LFRAME#/LAD.
`timescale 1ns/1ps
module lpc_host
  import lpc_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned LONG_TIMEOUT = 1024,
  parameter int unsigned ABORT_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic [1:0]  rsp_status_o,
  output logic        lframe_o,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  input  logic [3:0]  lad_i
);

  localparam int unsigned CntW = (ABORT_CYCLES > 4) ? $clog2(ABORT_CYCLES) : 2;

  lpc_state_e  r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic        r_write, r_err, r_rsp_valid;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata, r_rdata, r_rsp_data;
  lpc_status_e r_rsp_status;

  logic w_accept, w_done, w_abort_done, w_sync_err;
  logic w_timer_clr, w_short_inc, w_long_inc, w_short_tc, w_long_tc;
  logic w_cnt_one;

  assign w_cnt_one = (r_cnt == CntW'(1));

  lpc_sync_timer #(
    .SYNC_TIMEOUT(SYNC_TIMEOUT),
    .LONG_TIMEOUT(LONG_TIMEOUT)
  ) u_sync_timer (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (w_timer_clr),
    .short_inc_i(w_short_inc),
    .long_inc_i (w_long_inc),
    .short_tc_o (w_short_tc),
    .long_tc_o  (w_long_tc)
  );

  always_comb begin
    w_state_d    = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_abort_done = 1'b0;
    w_sync_err   = 1'b0;
    w_timer_clr  = 1'b0;
    w_short_inc  = 1'b0;
    w_long_inc   = 1'b0;
    case (r_state)
      StIdle: begin
        if (req_valid_i) begin
          w_accept  = 1'b1;
          w_state_d = StStart;
        end
      end
      StStart:   w_state_d = StCycType;
      StCycType: w_state_d = StAddr;
      StAddr:    if (r_cnt == CntW'(3)) w_state_d = r_write ? StWData : StHtar;
      StWData:   if (w_cnt_one) w_state_d = StHtar;
      StHtar: begin
        if (w_cnt_one) begin
          w_state_d   = StSync;
          w_timer_clr = 1'b1;
        end
      end
      StSync: begin
        if (lad_i == SyncReady || lad_i == SyncErr) begin
          w_sync_err = (lad_i == SyncErr);
          w_state_d  = r_write ? StPtar : StRData;
        end else if (lad_i == SyncLong) begin
          w_long_inc = 1'b1;
          if (w_long_tc) w_state_d = StAbort;
        end else begin
          // Short wait, no response and unknown codes all count as short.
          w_short_inc = 1'b1;
          if (w_short_tc) w_state_d = StAbort;
        end
      end
      StRData:   if (w_cnt_one) w_state_d = StPtar;
      StPtar: begin
        if (w_cnt_one) begin
          w_state_d = StIdle;
          w_done    = 1'b1;
        end
      end
      StAbort:   if (r_cnt == CntW'(ABORT_CYCLES - 1)) w_state_d = StRecover;
      StRecover: begin
        w_state_d    = StIdle;
        w_abort_done = 1'b1;
      end
      default:   w_state_d = StIdle;
    endcase
    w_cnt_d = (w_state_d != r_state) ? '0 : r_cnt + CntW'(1);
  end

  // Bus outputs decode registered state only, so lad_i never reaches a pin.
  always_comb begin
    lframe_o = 1'b1;
    lad_oe_o = 1'b0;
    lad_o    = 4'hF;
    case (r_state)
      StStart: begin
        lframe_o = 1'b0;
        lad_oe_o = 1'b1;
        lad_o    = LpcStartTpm;
      end
      StCycType: begin
        lad_oe_o = 1'b1;
        lad_o    = r_write ? CycTpmWrite : CycTpmRead;
      end
      StAddr: begin
        lad_oe_o = 1'b1;
        case (r_cnt[1:0])
          2'd0:    lad_o = r_addr[15:12];
          2'd1:    lad_o = r_addr[11:8];
          2'd2:    lad_o = r_addr[7:4];
          default: lad_o = r_addr[3:0];
        endcase
      end
      StWData: begin
        lad_oe_o = 1'b1;
        lad_o    = r_cnt[0] ? r_wdata[7:4] : r_wdata[3:0];
      end
      StHtar:  lad_oe_o = (r_cnt == '0);
      StAbort: begin
        lframe_o = 1'b0;
        lad_oe_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= StatusOk;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_rsp_valid <= w_done | w_abort_done;
      if (w_accept) begin
        r_write <= req_write_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_data_i;
        r_err   <= 1'b0;
      end
      if (w_sync_err) r_err <= 1'b1;
      if (r_state == StRData) begin
        if (r_cnt[0]) r_rdata[7:4] <= lad_i;
        else          r_rdata[3:0] <= lad_i;
      end
      if (w_done) begin
        r_rsp_data   <= r_write ? 8'h00 : r_rdata;
        r_rsp_status <= r_err ? StatusSyncErr : StatusOk;
      end
      if (w_abort_done) r_rsp_status <= StatusAbort;
    end
  end

  assign req_ready_o  = (r_state == StIdle);
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_data_o   = r_rsp_data;
  assign rsp_status_o = r_rsp_status;

endmodule

// File: tb/tb_lpc_host.sv
// Self-checking bench for lpc_host: table of TPM cycles with a scripted target model.
`timescale 1ns/1ps
module tb_lpc_host;
  import lpc_pkg::*;

  logic        clk, rstn;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_status;
  logic        lframe, lad_oe;
  logic [3:0]  lad_out, lad_in;

  lpc_host #(
    .SYNC_TIMEOUT(8),
    .LONG_TIMEOUT(1024),
    .ABORT_CYCLES(4)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_status_o(rsp_status),
    .lframe_o    (lframe),
    .lad_o       (lad_out),
    .lad_oe_o    (lad_oe),
    .lad_i       (lad_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target script: nwait SYNC cycles of wait_code, then ready/error, then read nibbles.
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [3:0]  wait_code;
    int          nwait;
    bit          err;
    logic [3:0]  rd_lo;
    logic [3:0]  rd_hi;
    logic [1:0]  exp_status;
    logic [7:0]  exp_data;
    int          exp_len;
    int          exp_abort;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] status;
    int         len;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] tgt_code(input vec_t v, input int k);
    int s;
    s = k - (v.wr ? 10 : 8);
    if (s < 0) return 4'hF;
    if (s < v.nwait) return v.wait_code;
    if (s == v.nwait) return v.err ? SyncErr : SyncReady;
    if (!v.wr && s == v.nwait + 1) return v.rd_lo;
    if (!v.wr && s == v.nwait + 2) return v.rd_hi;
    return 4'hF;
  endfunction

  function automatic logic [3:0] exp_nibble(input vec_t v, input int k);
    case (k)
      0: return 4'h5;
      1: return v.wr ? 4'h2 : 4'h0;
      2: return v.addr[15:12];
      3: return v.addr[11:8];
      4: return v.addr[7:4];
      5: return v.addr[3:0];
      6: return v.wr ? v.wdata[3:0] : 4'hF;
      7: return v.wr ? v.wdata[7:4] : 4'hF;
      default: return 4'hF;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 of the response cycle.
  task automatic run_txn(input vec_t v, input string tag);
    int   k, sync_start, abort_cnt;
    bit   bus_bad, got, exp_oe;
    exp_t e, r;
    sync_start = v.wr ? 10 : 8;
    abort_cnt = 0;
    bus_bad = 0;
    got = 0;
    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_data  = v.wdata;
    e.data = v.exp_data;
    e.status = v.exp_status;
    e.len = v.exp_len;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (k < 1200 && !got) begin
      if (k < sync_start) begin
        exp_oe = (k != sync_start - 1);
        if (lad_oe !== exp_oe || lframe !== (k != 0) || (exp_oe && lad_out !== exp_nibble(v, k)))
          bus_bad = 1;
      end
      if (k > 0 && lframe === 1'b0 && lad_oe === 1'b1 && lad_out === 4'hF) abort_cnt++;
      if (rsp_valid === 1'b1) begin
        got = 1;
        if (sb.size() == 0) begin
          check({tag, " unexpected_rsp"}, 32'(1), 32'(0));
        end else begin
          r = sb.pop_front();
          check({tag, " rsp_data"}, 32'(rsp_data), 32'(r.data));
          check({tag, " rsp_status"}, 32'(rsp_status), 32'(r.status));
          check({tag, " rsp_latency"}, 32'(k), 32'(r.len));
          check({tag, " ready_with_rsp"}, 32'(req_ready), 32'(1));
        end
        lad_in = 4'hF;
      end else begin
        lad_in = tgt_code(v, k);
        @(posedge clk); #1;
        k++;
      end
    end
    if (!got) begin
      check({tag, " rsp_timeout"}, 32'(k), 32'(v.exp_len));
      void'(sb.pop_front());
    end
    check({tag, " bus_header"}, 32'(bus_bad), 32'(0));
    check({tag, " abort_cycles"}, 32'(abort_cnt), 32'(v.exp_abort));
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_data = '0;
    lad_in = 4'hF;

    //          wr  addr      wdata  wcode      nwait err lo    hi    status data   len   abort
    vecs[0] = '{1'b1, 16'h0018, 8'hA5, SyncShort, 0,    1'b0, 4'h0, 4'h0, 2'b00, 8'h00, 13,   0};
    vecs[1] = '{1'b0, 16'h0F00, 8'h00, SyncShort, 3,    1'b0, 4'hC, 4'h3, 2'b00, 8'h3C, 16,   0};
    vecs[2] = '{1'b0, 16'h0001, 8'h00, SyncShort, 0,    1'b1, 4'hF, 4'hF, 2'b01, 8'hFF, 13,   0};
    vecs[3] = '{1'b0, 16'h1234, 8'h00, 4'hF,      8,    1'b0, 4'h0, 4'h0, 2'b10, 8'hFF, 21,   4};
    vecs[4] = '{1'b1, 16'h00AA, 8'h55, 4'hF,      7,    1'b0, 4'h0, 4'h0, 2'b00, 8'h00, 20,   0};
    vecs[5] = '{1'b0, 16'h0024, 8'h00, SyncLong,  1023, 1'b0, 4'h7, 4'hE, 2'b00, 8'hE7, 1036, 0};
    vecs[6] = '{1'b0, 16'h0024, 8'h00, SyncLong,  1024, 1'b0, 4'h7, 4'hE, 2'b10, 8'hE7, 1037, 4};
    vecs[7] = '{1'b1, 16'h0C30, 8'h9E, SyncShort, 8,    1'b0, 4'h0, 4'h0, 2'b10, 8'hE7, 23,   4};
    vecs[8] = '{1'b1, 16'h0000, 8'h11, SyncShort, 0,    1'b0, 4'h0, 4'h0, 2'b00, 8'h00, 13,   0};

    #12;
    check("reset lframe", 32'(lframe), 32'(1));
    check("reset lad_oe", 32'(lad_oe), 32'(0));
    check("reset lad", 32'(lad_out), 32'hF);
    check("reset ready", 32'(req_ready), 32'(1));
    check("reset rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset rsp_data", 32'(rsp_data), 32'(0));
    check("reset rsp_status", 32'(rsp_status), 32'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Establish non-zero held data, then reset in the middle of ADDR.
    run_txn(vecs[1], "pre_reset");
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0F00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_addr lad_oe", 32'(lad_oe), 32'(1));
    #2 rstn = 1'b0;
    #1;
    check("async_rst lframe", 32'(lframe), 32'(1));
    check("async_rst lad_oe", 32'(lad_oe), 32'(0));
    check("async_rst lad", 32'(lad_out), 32'hF);
    check("async_rst ready", 32'(req_ready), 32'(1));
    check("async_rst rsp_data", 32'(rsp_data), 32'(0));
    check("async_rst rsp_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        if (rsp_valid === 1'b1) seen++;
        @(posedge clk); #1;
      end
      check("post_reset no_rsp", 32'(seen), 32'(0));
    end
    run_txn(vecs[1], "after_reset");
    check("scoreboard empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lpc_host.md
# lpc_host

Bus-functional LPC host (initiator) for the TwPM LPC/TPM link: the counterpart of the `lpc_periph` target. It turns single-byte TPM read/write requests into LPC TPM cycles on `LFRAME`/`LAD` and returns the read data plus a completion status. It is used for on-FPGA loopback self-test of the TPM register interface and as a synthesizable stimulus source in the verification environment. `LAD` is split into `lad_o`, `lad_oe_o` and `lad_i`; the top level builds the tristate.

## Interface
- `SYNC_TIMEOUT`, default 8: maximum SYNC cycles with no response (`1111`) or short wait (`0101`) before abort.
- `LONG_TIMEOUT`, default 1024: maximum consecutive long-wait (`0110`) SYNC cycles before abort.
- `ABORT_CYCLES`, default 4: `lframe_o`-low cycles in an abort sequence (minimum 4).
- `clk_i`, in, 1: LPC clock; all logic on its rising edge.
- `rstn_i`, in, 1: asynchronous, active-low reset.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: high exactly when the block is in IDLE.
- `req_write_i`, in, 1: 1 = TPM write, 0 = TPM read.
- `req_addr_i`, in, 16: TPM address.
- `req_data_i`, in, 8: write data.
- `rsp_valid_o`, out, 1: one-cycle completion pulse.
- `rsp_data_o`, out, 8: read data, held until the next response; 8'h00 for writes.
- `rsp_status_o`, out, 2: 00 OK, 01 SYNC error, 10 timeout/abort.
- `lframe_o`, out, 1: LFRAME#, active-low.
- `lad_o`, out, 4: LAD drive value.
- `lad_oe_o`, out, 1: LAD output enable.
- `lad_i`, in, 4: sampled LAD.

## Operation
- States: IDLE, START, CYCTYPE, ADDR, WDATA, HTAR, SYNC, RDATA, PTAR, ABORT, RECOVER.
- **IDLE**
  - `lframe_o`=1, `lad_oe_o`=0, `lad_o`=4'hF.
  - On `req_valid_i & req_ready_o`, capture write flag, address and data, then go to START.
- **START**: `lframe_o`=0, drive `0101` (TPM start).
- **CYCTYPE**: drive `0010` for a write or `0000` for a read. `lframe_o` is 1 from here on.
- **ADDR**: 4 cycles, address nibbles MSB first (`[15:12]` … `[3:0]`).
- **WDATA**: writes only; 2 cycles, `data[3:0]` then `data[7:4]`.
- **HTAR**: 2 cycles. Cycle 1 drives `1111` with `lad_oe_o`=1; cycle 2 sets `lad_oe_o`=0. `lad_oe_o` stays 0 through PTAR.
- **SYNC**: sample `lad_i` each cycle.
  - `0000` ready: go to RDATA for a read, PTAR for a write.
  - `1010` error: latch status 01 and continue exactly as for ready.
  - `0101` or `1111`: increment the short counter; on reaching `SYNC_TIMEOUT`, go to ABORT.
  - `0110`: increment the long counter; on reaching `LONG_TIMEOUT`, go to ABORT. Both counters clear on entering SYNC.
  - Any other code is treated as `1111`.
- **RDATA**: 2 cycles, low nibble then high nibble into `rsp_data_o`.
- **PTAR**: 2 cycles, inputs ignored. Then return to IDLE with `rsp_valid_o`=1 that cycle.
- **ABORT**: `lframe_o`=0 and drive `1111` with `lad_oe_o`=1 for `ABORT_CYCLES`.
- **RECOVER**: 1 cycle with `lframe_o`=1 and `lad_oe_o`=0. Then IDLE with `rsp_valid_o`=1 and status 10; `rsp_data_o` is unchanged on abort.
- Requests are ignored outside IDLE; there is no queueing.

## Timing
- Reset values (asynchronous, while `rstn_i`=0):
  - state IDLE, `req_ready_o`=1, `rsp_valid_o`=0, `rsp_data_o`=8'h00, `rsp_status_o`=00;
  - `lframe_o`=1, `lad_o`=4'hF, `lad_oe_o`=0.
- Reset mid-cycle: the bus is released immediately and no response is emitted.
- The request is accepted at edge N; START is on the bus in cycle N+1.
- Minimum cycle length is 13 clocks from START to the last PTAR cycle, for both reads and writes (1 SYNC cycle).
- `rsp_valid_o` is asserted in the cycle after the last PTAR or RECOVER cycle. `req_ready_o` is 1 in that same cycle, so back-to-back accept is allowed.
- All bus outputs are registered; no combinational path from `lad_i` to any output.
- Counter widths are `$clog2(LONG_TIMEOUT+1)` and `$clog2(SYNC_TIMEOUT+1)`.
- Timeout boundary: abort is entered on the cycle the count reaches the limit, so exactly `SYNC_TIMEOUT` no-response SYNC cycles are tolerated.

## Structure
- Shared package `lpc_pkg` holds:
  - START code `0101`;
  - CYCTYPE codes `0000`/`0010`;
  - SYNC codes `0000`/`0101`/`0110`/`1010`;
  - status encodings;
  - the state enum.
- `lpc_periph` also imports the codes from `lpc_pkg`.
- One sub-module, `lpc_sync_timer`, implements the two SYNC counters with clear, increment and terminal-count outputs.

## Test plan
- Write addr 16'h0018, data 8'hA5, target responds SYNC `0000` on the first cycle:
  - bus shows `0101`, `0010`, `0`, `0`, `1`, `8`, `5`, `A`, then HTAR `F`/Z;
  - `rsp_valid_o` rises 13 clocks after START with status 00.
- Read addr 16'h0F00 with 3 short waits, then `0000`, then data nibbles `C`,`3`: `rsp_data_o`=8'h3C, status 00, 16-clock cycle.
- Read with SYNC `1010`, data `F`,`F`: status 01, `rsp_data_o`=8'hFF, full data phase consumed.
- No target (`lad_i`=`1111`) with `SYNC_TIMEOUT`=8:
  - after 8 SYNC cycles, `lframe_o` is low for 4 cycles with `1111` driven;
  - then 1 RECOVER cycle, then status 10.
- Long wait held for 1023 cycles, then `0000`: completes OK. Held for 1024 cycles: abort.
- `rstn_i` pulsed low during ADDR: outputs take their reset values asynchronously and no `rsp_valid_o`. A subsequent request completes normally.
